// File: rtl/dma_rx_rd_ctrl.sv
// DMA RX read controller: replays completed read tags from the lane RAMs
// strictly in request-issue order as a 128-bit ready/valid stream.
module dma_rx_rd_ctrl #(
    parameter int RAM_RD_LAT = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [4:0]   req_tag,
    input  logic [10:0]  req_dw_len,
    input  logic         tag_rc_done,
    input  logic [4:0]   tag_rc_number,
    output logic         ram_rd_en,
    output logic [12:0]  ram_rd_addr,
    input  logic [127:0] ram_rd_data,
    output logic         m_valid,
    output logic [127:0] m_data,
    output logic [3:0]   m_keep,
    output logic         m_last,
    input  logic         m_ready,
    output logic         tag_free_valid,
    output logic [4:0]   tag_free_num,
    output logic         err_done
);

    localparam int SPW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int SCW = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FREE} state_t;

    state_t state_q, state_d;
    logic [4:0] tag_q, tag_d, beat_q, beat_d, last_idx_q, last_idx_d;
    logic [1:0] len_lo_q, len_lo_d;

    logic [15:0] ord_mem [32];
    logic [5:0] ord_wp_q, ord_wp_d, ord_rp_q, ord_rp_d;
    logic ord_full, ord_empty, push, pop;
    logic [4:0] head_tag;
    logic [10:0] head_len;
    logic [11:0] nbm1;

    logic [31:0] out_q, out_d, done_q, done_d;
    logic err_q, err_d, is_out;

    logic [RAM_RD_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
    logic [3:0] pk_q [RAM_RD_LAT];
    logic [3:0] pk_d [RAM_RD_LAT];
    logic rd_last;
    logic [3:0] rd_keep;

    logic [127:0] sk_data [SKID_DEPTH];
    logic [3:0] sk_keep [SKID_DEPTH];
    logic sk_last [SKID_DEPTH];
    logic [SPW-1:0] sk_wp_q, sk_wp_d, sk_rp_q, sk_rp_d;
    logic [SCW-1:0] sk_cnt_q, sk_cnt_d;
    logic sk_push, sk_pop, credit;
    int inflight;

    function automatic logic [SPW-1:0] nxt(input logic [SPW-1:0] p);
        return (p == SPW'(SKID_DEPTH - 1)) ? '0 : p + SPW'(1);
    endfunction

    assign ord_full = (ord_wp_q[5] != ord_rp_q[5]) &&
                      (ord_wp_q[4:0] == ord_rp_q[4:0]);
    assign ord_empty = (ord_wp_q == ord_rp_q);
    assign req_ready = !ord_full;
    assign push = req_valid && !ord_full;
    assign pop = (state_q == S_FREE);
    assign head_tag = ord_mem[ord_rp_q[4:0]][15:11];
    assign head_len = ord_mem[ord_rp_q[4:0]][10:0];

    assign ram_rd_addr = {tag_q, beat_q};
    assign tag_free_valid = (state_q == S_FREE);
    assign tag_free_num = (state_q == S_FREE) ? tag_q : 5'd0;
    assign err_done = err_q;

    assign sk_push = pv_q[RAM_RD_LAT-1];
    assign m_valid = (sk_cnt_q != '0);
    assign sk_pop = m_valid && m_ready;
    assign m_data = m_valid ? sk_data[sk_rp_q] : '0;
    assign m_keep = m_valid ? sk_keep[sk_rp_q] : '0;
    assign m_last = m_valid && sk_last[sk_rp_q];

    // Read credit: pipeline plus skid occupancy must leave room for one more beat
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RAM_RD_LAT; i++) inflight += int'(pv_q[i]);
        credit = (inflight + int'(sk_cnt_q)) < SKID_DEPTH;
    end

    // Sequencer: pick done head tag, issue its beats, wait drain, release
    always_comb begin
        state_d = state_q;
        tag_d = tag_q;
        beat_d = beat_q;
        last_idx_d = last_idx_q;
        len_lo_d = len_lo_q;
        ram_rd_en = 1'b0;
        rd_last = 1'b0;
        rd_keep = 4'hF;
        nbm1 = (({1'b0, head_len} + 12'd3) >> 2) - 12'd1;
        unique case (state_q)
            S_IDLE: begin
                if (!ord_empty && done_q[head_tag]) begin
                    tag_d = head_tag;
                    len_lo_d = head_len[1:0];
                    last_idx_d = nbm1[4:0];
                    beat_d = 5'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (credit) begin
                    ram_rd_en = 1'b1;
                    beat_d = beat_q + 5'd1;
                    if (beat_q == last_idx_q) begin
                        rd_last = 1'b1;
                        unique case (len_lo_q)
                            2'd0: rd_keep = 4'b1111;
                            2'd1: rd_keep = 4'b0001;
                            2'd2: rd_keep = 4'b0011;
                            2'd3: rd_keep = 4'b0111;
                        endcase
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (m_valid && m_ready && m_last) state_d = S_FREE;
            end
            S_FREE: state_d = S_IDLE;
        endcase
    end

    // Order FIFO pointers and tag bitmaps, including done-pulse validation
    always_comb begin
        ord_wp_d = ord_wp_q + {5'd0, push};
        ord_rp_d = ord_rp_q + {5'd0, pop};
        out_d = out_q;
        done_d = done_q;
        err_d = 1'b0;
        is_out = out_q[tag_rc_number] || (push && req_tag == tag_rc_number);
        if (pop) begin
            out_d[tag_q] = 1'b0;
            done_d[tag_q] = 1'b0;
        end
        if (push) out_d[req_tag] = 1'b1;
        if (tag_rc_done) begin
            if (!is_out || done_q[tag_rc_number] ||
                (pop && tag_q == tag_rc_number))
                err_d = 1'b1;
            else
                done_d[tag_rc_number] = 1'b1;
        end
    end

    // Sideband pipeline matching RAM latency, then skid FIFO bookkeeping
    always_comb begin
        pv_d[0] = ram_rd_en;
        pl_d[0] = rd_last;
        pk_d[0] = rd_keep;
        for (int i = 1; i < RAM_RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
            pk_d[i] = pk_q[i-1];
        end
        sk_wp_d = sk_push ? nxt(sk_wp_q) : sk_wp_q;
        sk_rp_d = sk_pop ? nxt(sk_rp_q) : sk_rp_q;
        sk_cnt_d = sk_cnt_q;
        if (sk_push && !sk_pop) sk_cnt_d = sk_cnt_q + SCW'(1);
        else if (!sk_push && sk_pop) sk_cnt_d = sk_cnt_q - SCW'(1);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q <= '0;
            beat_q <= '0;
            last_idx_q <= '0;
            len_lo_q <= '0;
            ord_wp_q <= '0;
            ord_rp_q <= '0;
            out_q <= '0;
            done_q <= '0;
            err_q <= 1'b0;
            pv_q <= '0;
            pl_q <= '0;
            for (int i = 0; i < RAM_RD_LAT; i++) pk_q[i] <= '0;
            sk_wp_q <= '0;
            sk_rp_q <= '0;
            sk_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q <= tag_d;
            beat_q <= beat_d;
            last_idx_q <= last_idx_d;
            len_lo_q <= len_lo_d;
            ord_wp_q <= ord_wp_d;
            ord_rp_q <= ord_rp_d;
            out_q <= out_d;
            done_q <= done_d;
            err_q <= err_d;
            pv_q <= pv_d;
            pl_q <= pl_d;
            for (int i = 0; i < RAM_RD_LAT; i++) pk_q[i] <= pk_d[i];
            sk_wp_q <= sk_wp_d;
            sk_rp_q <= sk_rp_d;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    // Storage arrays; contents are only read behind valid pointers
    always_ff @(posedge clk) begin
        if (push) ord_mem[ord_wp_q[4:0]] <= {req_tag, req_dw_len};
        if (sk_push) begin
            sk_data[sk_wp_q] <= ram_rd_data;
            sk_keep[sk_wp_q] <= pk_q[RAM_RD_LAT-1];
            sk_last[sk_wp_q] <= pl_q[RAM_RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_dma_rx_rd_ctrl.sv
// Directed bench for dma_rx_rd_ctrl with a 2-cycle RAM model.
// Events are logged per cycle; each test task checks its own log.
module tb_dma_rx_rd_ctrl;
    localparam int LAT = 2;
    localparam int DEPTH = 4;

    logic clk, rst_n;
    logic req_valid, req_ready;
    logic [4:0] req_tag;
    logic [10:0] req_dw_len;
    logic tag_rc_done;
    logic [4:0] tag_rc_number;
    logic ram_rd_en;
    logic [12:0] ram_rd_addr;
    logic [127:0] ram_rd_data;
    logic m_valid, m_last, m_ready;
    logic [127:0] m_data;
    logic [3:0] m_keep;
    logic tag_free_valid, err_done;
    logic [4:0] tag_free_num;

    dma_rx_rd_ctrl #(.RAM_RD_LAT(LAT), .SKID_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_dw_len(req_dw_len),
        .tag_rc_done(tag_rc_done), .tag_rc_number(tag_rc_number),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep),
        .m_last(m_last), .m_ready(m_ready),
        .tag_free_valid(tag_free_valid), .tag_free_num(tag_free_num),
        .err_done(err_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 0;

    function automatic logic [127:0] beat_of(input logic [12:0] a);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = {3'b0, a, 14'h0, 2'(i)};
        return r;
    endfunction

    // RAM model: data for the address of cycle T is valid in cycle T+2
    logic [12:0] ra0;
    always @(posedge clk) begin
        ra0 <= ram_rd_addr;
        ram_rd_data <= beat_of(ra0);
    end

    always @(negedge clk) if (rdy_mode == 1) m_ready = ~m_ready;

    int rd_cyc[$];
    logic [12:0] rd_adr[$];
    int bt_cyc[$];
    logic [127:0] bt_dat[$];
    logic [3:0] bt_keep[$];
    logic bt_last[$];
    int fr_cyc[$];
    logic [4:0] fr_num[$];
    int er_cyc[$];
    int outst = 0;
    int max_outst = 0;
    int stall_bad = 0;
    logic prev_stall = 1'b0;
    logic [133:0] prev_out;

    // Cycle-stamped event log of everything the DUT emits
    always @(posedge clk) begin
        if (!rst_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            if (ram_rd_en) begin
                rd_cyc.push_back(cyc);
                rd_adr.push_back(ram_rd_addr);
                outst++;
            end
            if (m_valid && m_ready) begin
                bt_cyc.push_back(cyc);
                bt_dat.push_back(m_data);
                bt_keep.push_back(m_keep);
                bt_last.push_back(m_last);
                outst--;
            end
            if (outst > max_outst) max_outst = outst;
            if (prev_stall && {m_valid, m_data, m_keep, m_last} !== prev_out)
                stall_bad++;
            prev_stall = m_valid && !m_ready;
            prev_out = {m_valid, m_data, m_keep, m_last};
            if (tag_free_valid) begin
                fr_cyc.push_back(cyc);
                fr_num.push_back(tag_free_num);
            end
            if (err_done) er_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_adr.delete();
        bt_cyc.delete(); bt_dat.delete(); bt_keep.delete(); bt_last.delete();
        fr_cyc.delete(); fr_num.delete(); er_cyc.delete();
        max_outst = 0;
        stall_bad = 0;
    endtask

    task automatic push(input logic [4:0] t, input logic [10:0] l);
        @(negedge clk);
        req_valid = 1'b1; req_tag = t; req_dw_len = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic done(input logic [4:0] t, output int n);
        @(negedge clk);
        tag_rc_done = 1'b1; tag_rc_number = t; n = cyc;
        @(negedge clk);
        tag_rc_done = 1'b0;
    endtask

    task automatic wait_free(input int n, input int budget);
        for (int i = 0; i < budget && fr_num.size() < n; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_dw_len = '0;
        tag_rc_done = 1'b0; tag_rc_number = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, m_valid, ram_rd_en, tag_free_valid, err_done, m_last}
            !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 100000",
                {req_ready, m_valid, ram_rd_en, tag_free_valid, err_done, m_last});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        clear_logs();
        push(5'd3, 11'd8);
        done(5'd3, n);
        wait_free(1, 60);
        n_cmp++;
        if (rd_cyc.size() != 2 || rd_adr[0] !== 13'd96 || rd_adr[1] !== 13'd97
            || rd_cyc[0] != n + 2 || rd_cyc[1] != n + 3) begin
            n_bad++;
            $display("FAIL single_rd: got %0d reads first @%0d want 96,97 @%0d",
                rd_cyc.size(), rd_cyc.size() > 0 ? rd_cyc[0] - n : -1, 2);
        end
        n_cmp++;
        if (bt_cyc.size() != 2 || bt_cyc[0] != n + 3 + LAT || bt_cyc[1] != n + 4 + LAT) begin
            n_bad++;
            $display("FAIL single_beat_time: got %0d beats first @+%0d want 2 @+%0d",
                bt_cyc.size(), bt_cyc.size() > 0 ? bt_cyc[0] - n : -1, 3 + LAT);
        end else begin
            n_cmp++;
            if (bt_dat[0] !== beat_of(13'd96) || bt_dat[1] !== beat_of(13'd97)
                || bt_keep[0] !== 4'hF || bt_keep[1] !== 4'hF
                || bt_last[0] !== 1'b0 || bt_last[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL single_beat_data: keep %h/%h last %b/%b want f/f 0/1",
                    bt_keep[0], bt_keep[1], bt_last[0], bt_last[1]);
            end
            n_cmp++;
            if (fr_cyc.size() != 1 || fr_num[0] !== 5'd3 || fr_cyc[0] != bt_cyc[1] + 1) begin
                n_bad++;
                $display("FAIL single_free: got %0d frees want tag 3 one cycle after last",
                    fr_cyc.size());
            end
        end
    endtask

    task automatic test_out_of_order();
        int n6, n5;
        clear_logs();
        push(5'd5, 11'd5);
        push(5'd6, 11'd4);
        done(5'd6, n6);
        repeat (12) @(negedge clk);
        n_cmp++;
        if (bt_cyc.size() != 0 || rd_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL ooo_hold: got %0d beats %0d reads want 0",
                bt_cyc.size(), rd_cyc.size());
        end
        done(5'd5, n5);
        wait_free(2, 80);
        n_cmp++;
        if (rd_adr.size() != 3 || rd_adr[0] !== 13'd160 || rd_adr[1] !== 13'd161
            || rd_adr[2] !== 13'd192 || rd_cyc[0] != n5 + 2) begin
            n_bad++;
            $display("FAIL ooo_addr: got %0d reads want 160,161,192", rd_adr.size());
        end
        n_cmp++;
        if (bt_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL ooo_beats: got %0d want 3", bt_cyc.size());
        end else begin
            n_cmp++;
            if (bt_dat[0] !== beat_of(13'd160) || bt_dat[1] !== beat_of(13'd161)
                || bt_dat[2] !== beat_of(13'd192) || bt_keep[0] !== 4'hF
                || bt_keep[1] !== 4'h1 || bt_keep[2] !== 4'hF
                || {bt_last[0], bt_last[1], bt_last[2]} !== 3'b011) begin
                n_bad++;
                $display("FAIL ooo_content: keep %h %h %h want f 1 f",
                    bt_keep[0], bt_keep[1], bt_keep[2]);
            end
            n_cmp++;
            if (rd_adr.size() == 3 && rd_cyc[2] != bt_cyc[1] + 3) begin
                n_bad++;
                $display("FAIL ooo_gap: got next read @+%0d want +3",
                    rd_cyc[2] - bt_cyc[1]);
            end
        end
        n_cmp++;
        if (fr_num.size() != 2 || fr_num[0] !== 5'd5 || fr_num[1] !== 5'd6) begin
            n_bad++;
            $display("FAIL ooo_free_order: got %0d frees want 5 then 6", fr_num.size());
        end
    endtask

    task automatic test_backpressure();
        int n, bad;
        clear_logs();
        push(5'd1, 11'd128);
        rdy_mode = 1;
        done(5'd1, n);
        wait_free(1, 400);
        rdy_mode = 0;
        m_ready = 1'b1;
        bad = 0;
        n_cmp++;
        if (bt_cyc.size() != 32) begin
            n_bad++;
            $display("FAIL bp_count: got %0d want 32", bt_cyc.size());
        end else begin
            for (int k = 0; k < 32; k++)
                if (bt_dat[k] !== beat_of(13'(32 + k)) || bt_keep[k] !== 4'hF
                    || bt_last[k] !== (k == 31)) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL bp_order: got %0d bad beats want 0", bad);
            end
        end
        n_cmp++;
        if (max_outst > DEPTH) begin
            n_bad++;
            $display("FAIL bp_credit: got %0d outstanding want <= %0d", max_outst, DEPTH);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL bp_stable: got %0d changes under stall want 0", stall_bad);
        end
    endtask

    task automatic test_errors();
        int n9, na, nb, nx;
        clear_logs();
        done(5'd9, n9);
        push(5'd10, 11'd4);
        push(5'd2, 11'd4);
        done(5'd2, na);
        done(5'd2, nb);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (er_cyc.size() != 2 || er_cyc[0] != n9 + 1 || er_cyc[1] != nb + 1) begin
            n_bad++;
            $display("FAIL err_pulses: got %0d want 2 at +1", er_cyc.size());
        end
        n_cmp++;
        if (bt_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL err_no_stream: got %0d beats want 0", bt_cyc.size());
        end
        @(negedge clk);
        req_valid = 1'b1; req_tag = 5'd11; req_dw_len = 11'd4;
        tag_rc_done = 1'b1; tag_rc_number = 5'd11;
        @(negedge clk);
        req_valid = 1'b0; tag_rc_done = 1'b0;
        done(5'd10, nx);
        wait_free(3, 100);
        n_cmp++;
        if (fr_num.size() != 3 || fr_num[0] !== 5'd10 || fr_num[1] !== 5'd2
            || fr_num[2] !== 5'd11 || er_cyc.size() != 2) begin
            n_bad++;
            $display("FAIL err_recover: got %0d frees %0d errs want 10,2,11 and 2",
                fr_num.size(), er_cyc.size());
        end
    endtask

    task automatic test_full();
        int n, bad;
        logic seen;
        clear_logs();
        for (int t = 0; t < 32; t++) push(5'(t), 11'd4);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: got %b want 0", req_ready);
        end
        push(5'd7, 11'd4);
        done(5'd0, n);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (tag_free_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (req_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_ready_free: got %b want 0", req_ready);
                end
                @(negedge clk);
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_ready_after: got %b want 1", req_ready);
                end
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL full_first_free: got %b want 1", seen);
        end
        for (int t = 1; t < 32; t++) done(5'(t), n);
        wait_free(32, 800);
        bad = 0;
        for (int k = 0; k < fr_num.size(); k++) if (fr_num[k] !== 5'(k)) bad++;
        n_cmp++;
        if (fr_num.size() != 32 || bad != 0 || bt_cyc.size() != 32) begin
            n_bad++;
            $display("FAIL full_drain: got %0d frees %0d beats %0d misordered want 32/32/0",
                fr_num.size(), bt_cyc.size(), bad);
        end
        er_cyc.delete();
        done(5'd7, n);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (er_cyc.size() != 1 || bt_cyc.size() != 32) begin
            n_bad++;
            $display("FAIL full_dropped_push: got %0d errs %0d beats want 1/32",
                er_cyc.size(), bt_cyc.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        clear_logs();
        push(5'd4, 11'd64);
        done(5'd4, n);
        while (cyc < n + 7) @(negedge clk);
        n_cmp++;
        if ({m_valid, ram_rd_en} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_pre: got %b want 11", {m_valid, ram_rd_en});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_valid, ram_rd_en, tag_free_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_drop: got %b want 000", {m_valid, ram_rd_en, tag_free_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ready: got %b want 1", req_ready);
        end
        repeat (25) @(negedge clk);
        n_cmp++;
        if (bt_cyc.size() != 0 || rd_cyc.size() != 0 || fr_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL rst_stale: got %0d beats %0d reads want 0",
                bt_cyc.size(), rd_cyc.size());
        end
        push(5'd5, 11'd3);
        done(5'd5, n);
        wait_free(1, 60);
        n_cmp++;
        if (bt_cyc.size() != 1 || bt_dat[0] !== beat_of(13'd160)
            || bt_keep[0] !== 4'h7 || bt_last[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_restart: got %0d beats want 1 beat keep 7",
                bt_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_backpressure();
        test_errors();
        test_full();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_rx_rd_ctrl.md
# dma_rx_rd_ctrl

Downstream stage of the DMA receive completion RAM. Holds the issue order of outstanding read-request tags and waits for each tag's completion-done pulse. Reads that tag's region out of the 4×32-bit lane RAMs strictly in request-issue order and presents it as a 128-bit ready/valid stream. Returns each tag to the tag allocator once its last beat is accepted downstream.

## Interface
- RAM_RD_LAT, 1: RAM read latency in cycles, from `ram_rd_en` to `ram_rd_data` valid; legal values 1 or 2.
- SKID_DEPTH, 4: output buffer depth in 128-bit beats; must be ≥ RAM_RD_LAT+1.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  read request issued upstream; push {req_tag, req_dw_len} into the order FIFO.
- req_ready  out  1  order FIFO not full (32 entries).
- req_tag  in  5  tag of the issued request.
- req_dw_len  in  11  request length in DWs, legal 1..128.
- tag_rc_done  in  1  one-cycle pulse: all completion data for `tag_rc_number` is written to RAM.
- tag_rc_number  in  5  tag completed.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  13  read address = {tag, 5'b beat}, i.e. tag*32 + beat index.
- ram_rd_data  in  128  lane3..lane0 read data; lane i = DW i of the beat.
- m_valid  out  1  output beat valid.
- m_data  out  128  output beat.
- m_keep  out  4  DW-lane enables, packed from lane 0.
- m_last  out  1  last beat of the current tag.
- m_ready  in  1  downstream accept.
- tag_free_valid  out  1  one-cycle pulse: tag released.
- tag_free_num  out  5  released tag.
- err_done  out  1  one-cycle pulse: a done pulse arrived for a tag that is not outstanding or is already marked done.

## Operation
- Order FIFO: 32×16 bits (tag, len). Push on req_valid&&req_ready. A push while full is dropped, and req_ready is already low. Pop happens in FREE.
- Outstanding bitmap (32): set on push for req_tag. Cleared in FREE.
- Done bitmap (32): set on tag_rc_done. If that tag's outstanding bit is 0, or its done bit is already 1, assert err_done the next cycle and leave the bitmaps unchanged.
- Beat count = ceil(len/4) = (len+3)>>2, range 1..32.
- Last-beat keep by len[1:0]: 0→1111, 1→0001, 2→0011, 3→0111. All other beats use 1111.
- FSM states:
  - IDLE: if the order FIFO is non-empty and the head tag's done bit is set, latch the head tag and len, set beat=0, go to READ.
  - READ: assert ram_rd_en when credit is available, i.e. in-flight reads + skid occupancy < SKID_DEPTH. Increment beat on each read. After issuing the final beat, go to DRAIN.
  - DRAIN: wait until the last beat is accepted (m_valid&&m_ready&&m_last). Go to FREE.
  - FREE: pulse tag_free_valid with tag_free_num. Clear the done and outstanding bits, pop the order FIFO, go to IDLE.
- A pipeline of RAM_RD_LAT stages carries {valid, keep, last} alongside each read. Returning data is written into the skid FIFO. m_* is the registered skid head.
- Tags complete out of order. A completed tag that is not at the head waits; there is no bypass.
- Simultaneous events:
  - A push and a pop in the same cycle are both performed.
  - tag_rc_done for a tag in the same cycle as its push is legal: outstanding is treated as set.
  - tag_rc_done for the tag being freed in the same cycle is an error: err_done, ignored.
- Reset (asynchronous, any state):
  - FSM to IDLE; FIFOs emptied; bitmaps cleared; in-flight reads discarded.
  - All outputs 0, except req_ready=1.

## Timing
- tag_rc_done for the head tag at cycle N: done bit set at N+1, FSM in READ at N+2, first ram_rd_en at N+2.
- First m_valid at N+3+RAM_RD_LAT.
- With m_ready held high: one beat per cycle; no bubbles within a tag.
- Gap between tags: 2 cycles of ram_rd_en low (FREE + IDLE), counted from the last beat's acceptance.
- tag_free_valid occurs exactly 1 cycle after the last beat is accepted.
- m_valid/m_data/m_keep/m_last stay stable while m_valid&&!m_ready.
- ram_rd_en is never asserted without credit. The skid buffer never overflows.

## Test plan
- Push tag 3 with len 8, then done(3) at N: ram_rd_addr 96, 97 at N+2, N+3. Two beats out, keep 1111/1111, m_last on the second. tag_free_num=3 one cycle after it is accepted.
- Push tags 5 (len 5), 6 (len 4); done(6) before done(5): nothing is output until done(5). Output order is tag 5 (2 beats, last keep 0001), then tag 6 (1 beat, keep 1111, addr 192).
- Tag 1 with len 128, m_ready toggling 1/0 each cycle: 32 beats with addresses 32..63 in order. No beat lost or duplicated; skid occupancy ≤ 4 with RAM_RD_LAT=2.
- done(9) with tag 9 not outstanding, then a second done(2) for tag 2: err_done pulses each time; no output stream.
- Push 32 tags: req_ready goes low; the 33rd push is ignored; req_ready returns to 1 the cycle after the first FREE.
- Assert rst_n low in the middle of the READ of a len-64 tag: m_valid, ram_rd_en and tag_free_valid drop immediately. After release, req_ready=1 and no stale beats appear.
